// File: rtl/tm_master_req_buffer.sv
// Request FIFO between a traffic-manager master and its credit gate.
// Latency: a word written at edge N is visible at out_data and poppable in cycle N+1. There is no fall-through path.
// Backpressure: in_ready drops while full or in reset. out_valid is raised only in a cycle where a word is actually sent.
//
// Ports:
//   clk        posedge clock for all state
//   rst        synchronous active-low reset (0 = reset)
//   in_data    request payload from the master
//   in_valid   master offers in_data
//   in_ready   buffer accepts in_data this cycle
//   out_data   head-of-queue payload (meaningful only while !empty)
//   out_valid  a word leaves this cycle; doubles as the credit gate's send_valid
//   out_ready  credit gate permits a send this cycle
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module tm_master_req_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // Flags come from the registered count only. A pop in a full cycle therefore
  // cannot reopen in_ready in the same cycle. A push into an empty FIFO cannot
  // be popped in the same cycle either.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign in_ready = rst && !full;
  assign push     = in_valid && in_ready;

  // The credit gate consumes a credit on every out_valid. The pulse is therefore
  // gated by out_ready here, so that each pulse is exactly one transfer.
  assign out_valid = rst && !empty && out_ready;
  assign pop       = out_valid;

  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage is intentionally not reset; out_data is don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Occupancy must never leave 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && !pop && count == DEPTH_C))
        else $fatal(1, "tm_master_req_buffer: count overflow");
      assert (!(pop && !push && count == '0))
        else $fatal(1, "tm_master_req_buffer: count underflow");
    end
  end

endmodule

// File: tb/tb_tm_master_req_buffer.sv
module tb_tm_master_req_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain queue of the words the master handed over, plus an
  // occupancy counter. Data checks pop from the queue. Flag checks use the counter.
  logic [WIDTH-1:0] scb[$];
  int               occ = 0;
  logic             took;

  tm_master_req_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data monitor: each out_valid pulse must carry the oldest unsent word.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (scb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_data: got %0h expected nothing (queue empty) at %0t", out_data, $time);
      end else begin
        chk("out_data", out_data, scb.pop_front());
      end
    end
  end

  // Status checker and model update. This runs after the data monitor in the same cycle.
  always @(negedge clk) begin
    logic exp_in_rdy;
    logic exp_out_vld;
    #1;
    exp_in_rdy  = rst && (occ < DEPTH);
    exp_out_vld = rst && (occ > 0) && out_ready;
    chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_in_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_out_vld});
    chk("count",     {29'b0, count},     WIDTH'(occ));
    chk("full",      {31'b0, full},      {31'b0, occ == DEPTH});
    chk("empty",     {31'b0, empty},     {31'b0, occ == 0});
    if (!rst) begin
      occ = 0;
      scb.delete();
    end else begin
      if (in_valid && exp_in_rdy) begin
        scb.push_back(in_data);
        occ++;
      end
      if (exp_out_vld) occ--;
    end
  end

  // Applies one cycle of stimulus. took reports whether the master's offer was accepted.
  task automatic cyc(input logic r, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    took = iv && in_ready;
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1: reset for three cycles, then release.
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);

    // 2: single word with out_ready held high.
    cyc(1'b1, 1'b1, 32'hA1, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);

    // 3: fill with the sink stalled, then hold a fifth offer.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'h10 + i, 1'b0);
    cyc(1'b1, 1'b1, 32'h14, 1'b0);
    cyc(1'b1, 1'b1, 32'h14, 1'b0);

    // 4: drain from full while the master keeps offering 0x14..0x17.
    v = 32'h14;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, v <= 32'h17, v, 1'b1);
      if (took) v++;
    end

    // 5: hold two entries, then push and pop together for six cycles.
    cyc(1'b1, 1'b1, 32'h20, 1'b0);
    cyc(1'b1, 1'b1, 32'h21, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 32'h22 + i, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, '0, 1'b1);

    // 6: reset while holding three entries, with the sink ready.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h30 + i, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, '0, 1'b1);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0);
    end

    repeat (8) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("drained", WIDTH'(scb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
